// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit and its store buffer.
// Byte-lane masks, alignment check, store lane shift and load align/extend live here.
package lsu_pkg;

  localparam int unsigned LSU_ADDR_W  = 32;
  localparam int unsigned LSU_WADDR_W = LSU_ADDR_W - 2;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ld_funct3_t;

  typedef enum logic [2:0] {
    ST_B = 3'b000,
    ST_H = 3'b001,
    ST_W = 3'b010
  } st_funct3_t;

  typedef enum logic [1:0] {L_IDLE, L_HAZ, L_REQ, L_WAIT} lsu_state_t;

  typedef struct packed {
    logic [LSU_WADDR_W-1:0] addr;
    logic [31:0]            data;
    logic [3:0]             mask;
  } sb_entry_t;

  // funct3[1:0] encodes access size for both loads and stores.
  function automatic logic [3:0] byte_mask(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [1:0] off);
    return wdata << {off, 3'b000};
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] s;
    s = word >> {off, 3'b000};
    case (funct3)
      LD_B:    return {{24{s[7]}}, s[7:0]};
      LD_H:    return {{16{s[15]}}, s[15:0]};
      LD_BU:   return {24'h0, s[7:0]};
      LD_HU:   return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_sb_fifo.sv
// Circular store buffer with head/tail/count and a parallel word-address probe.
// The probe reports the youngest matching entry and whether its mask covers the probe mask.
module mem_lsu_sb_fifo
  import lsu_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  sb_entry_t                   push_entry,
  input  logic                        pop,
  input  logic [LSU_WADDR_W-1:0]      probe_addr,
  input  logic [3:0]                  probe_mask,
  output sb_entry_t                   head_entry,
  output logic                        full,
  output logic                        empty,
  output logic                        hit,
  output logic [$clog2(SB_DEPTH)-1:0] hit_idx,
  output logic [31:0]                 hit_data,
  output logic                        full_cover
);

  localparam int unsigned PW = $clog2(SB_DEPTH);

  sb_entry_t     mem_q [SB_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0]   count_q;
  logic [PW-1:0] probe_idx;

  assign full       = count_q == (PW+1)'(SB_DEPTH);
  assign empty      = count_q == '0;
  assign head_entry = mem_q[head_q];

  // Pointers are PW bits wide, so increments wrap modulo SB_DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_entry;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Walk oldest to youngest so the last match is the youngest.
  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    probe_idx = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      probe_idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (mem_q[probe_idx].addr == probe_addr)) begin
        hit     = 1'b1;
        hit_idx = probe_idx;
      end
    end
  end

  assign hit_data   = mem_q[hit_idx].data;
  assign full_cover = hit && ((mem_q[hit_idx].mask & probe_mask) == probe_mask);

endmodule

// File: rtl/mem_lsu_sb.sv
// MEM-stage load/store unit: stores retire into a draining store buffer, loads probe it first.
// Define MEM_LSU_FWD_EN for full-coverage store-to-load forwarding; otherwise SB hits wait for drain.
module mem_lsu_sb
  import lsu_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  output logic [4:0]        out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign,
  output logic              dc_req_valid,
  input  logic              dc_req_ready,
  output logic              dc_req_we,
  output logic [ADDR_W-1:0] dc_req_addr,
  output logic [DATA_W-1:0] dc_req_wdata,
  output logic [3:0]        dc_req_wmask,
  input  logic              dc_resp_valid,
  input  logic [DATA_W-1:0] dc_resp_rdata,
  output logic              sb_empty
);

  lsu_state_t             state_q;
  logic [2:0]             ld_funct3_q;
  logic [1:0]             ld_off_q;
  logic [LSU_WADDR_W-1:0] ld_waddr_q;
  logic [4:0]             ld_rd_q;
  logic                   out_valid_q, out_misalign_q;
  logic [4:0]             out_rd_q;
  logic [DATA_W-1:0]      out_data_q;

  logic                        is_load, is_store, acc_mis, accept, push, pop, drain_valid;
  logic [1:0]                  off;
  logic [3:0]                  acc_mask;
  sb_entry_t                   push_entry, head_entry;
  logic                        sb_full, sb_hit, sb_full_cover;
  logic [$clog2(SB_DEPTH)-1:0] sb_hit_idx;
  logic [31:0]                 sb_hit_data;

  assign is_load  = in_is_load;
  assign is_store = in_is_store && !in_is_load;
  assign off      = in_addr[1:0];
  assign acc_mask = byte_mask(in_funct3, off);
  assign acc_mis  = (is_load || is_store) && misaligned(in_funct3, off);

  // Full check uses the registered count: a same-cycle pop does not free a slot.
  assign in_ready = (state_q == L_IDLE) && !(is_store && sb_full);
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_store && !acc_mis;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = in_addr[ADDR_W-1:2];
    push_entry.data = store_data(in_wdata, off);
    push_entry.mask = acc_mask;
  end

  // A pending load read owns the port; drain resumes once the load completes.
  assign drain_valid  = !sb_empty && (state_q != L_REQ) && (state_q != L_WAIT);
  assign pop          = drain_valid && dc_req_ready;
  assign dc_req_valid = (state_q == L_REQ) || drain_valid;
  assign dc_req_we    = drain_valid;
  assign dc_req_addr  = (state_q == L_REQ) ? {ld_waddr_q, 2'b00} : {head_entry.addr, 2'b00};
  assign dc_req_wdata = drain_valid ? head_entry.data : '0;
  assign dc_req_wmask = drain_valid ? head_entry.mask : 4'b0000;

  mem_lsu_sb_fifo #(
    .SB_DEPTH(SB_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .probe_addr(in_addr[ADDR_W-1:2]),
    .probe_mask(acc_mask),
    .head_entry(head_entry),
    .full      (sb_full),
    .empty     (sb_empty),
    .hit       (sb_hit),
    .hit_idx   (sb_hit_idx),
    .hit_data  (sb_hit_data),
    .full_cover(sb_full_cover)
  );

  logic unused_hit_idx;
  assign unused_hit_idx = ^sb_hit_idx;
`ifndef MEM_LSU_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{sb_hit_data, sb_full_cover};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= L_IDLE;
      ld_funct3_q    <= '0;
      ld_off_q       <= '0;
      ld_waddr_q     <= '0;
      ld_rd_q        <= '0;
      out_valid_q    <= 1'b0;
      out_misalign_q <= 1'b0;
      out_rd_q       <= '0;
      out_data_q     <= '0;
    end else begin
      out_valid_q    <= 1'b0;
      out_misalign_q <= 1'b0;
      unique case (state_q)
        L_IDLE: begin
          if (accept) begin
            out_rd_q   <= '0;
            out_data_q <= '0;
            if (acc_mis) begin
              out_valid_q    <= 1'b1;
              out_misalign_q <= 1'b1;
              out_rd_q       <= is_load ? in_rd : 5'd0;
            end else if (is_store) begin
              out_valid_q <= 1'b1;
            end else if (is_load) begin
              ld_funct3_q <= in_funct3;
              ld_off_q    <= off;
              ld_waddr_q  <= in_addr[ADDR_W-1:2];
              ld_rd_q     <= in_rd;
`ifdef MEM_LSU_FWD_EN
              if (sb_full_cover) begin
                out_valid_q <= 1'b1;
                out_rd_q    <= in_rd;
                out_data_q  <= load_extend(in_funct3, off, sb_hit_data);
              end else begin
                state_q <= sb_hit ? L_HAZ : L_REQ;
              end
`else
              state_q <= sb_hit ? L_HAZ : L_REQ;
`endif
            end else begin
              out_valid_q <= 1'b1;
              out_rd_q    <= in_rd;
              out_data_q  <= in_addr;
            end
          end
        end
        L_HAZ: if (sb_empty) state_q <= L_REQ;
        L_REQ: if (dc_req_ready) state_q <= L_WAIT;
        L_WAIT: begin
          if (dc_resp_valid) begin
            out_valid_q <= 1'b1;
            out_rd_q    <= ld_rd_q;
            out_data_q  <= load_extend(ld_funct3_q, ld_off_q, dc_resp_rdata);
            state_q     <= L_IDLE;
          end
        end
        default: state_q <= L_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_rd       = out_rd_q;
  assign out_data     = out_data_q;
  assign out_misalign = out_misalign_q;

endmodule

// File: tb/tb_mem_lsu_sb.sv
// Scoreboard bench for mem_lsu_sb: directed ops push expected results, a monitor pops on out_valid.
// A behavioural D-cache answers reads two cycles after acceptance and applies masked writes.
module tb_mem_lsu_sb;

  localparam int unsigned SB_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0, in_ready, in_is_load = 1'b0, in_is_store = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [4:0]  in_rd = '0;
  logic        out_valid, out_misalign;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic        dc_req_valid, dc_req_ready = 1'b1, dc_req_we;
  logic [31:0] dc_req_addr, dc_req_wdata;
  logic [3:0]  dc_req_wmask;
  logic        dc_resp_valid = 1'b0;
  logic [31:0] dc_resp_rdata = '0;
  logic        sb_empty;

  mem_lsu_sb #(
    .SB_DEPTH(SB_DEPTH),
    .ADDR_W  (32),
    .DATA_W  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_load   (in_is_load),
    .in_is_store  (in_is_store),
    .in_funct3    (in_funct3),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_rd       (out_rd),
    .out_data     (out_data),
    .out_misalign (out_misalign),
    .dc_req_valid (dc_req_valid),
    .dc_req_ready (dc_req_ready),
    .dc_req_we    (dc_req_we),
    .dc_req_addr  (dc_req_addr),
    .dc_req_wdata (dc_req_wdata),
    .dc_req_wmask (dc_req_wmask),
    .dc_resp_valid(dc_resp_valid),
    .dc_resp_rdata(dc_resp_rdata),
    .sb_empty     (sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    bit          chk_rd;
    bit          chk_data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0, bad = 0;
  logic [31:0] cmem [1024];
  int          resp_cnt = 0, n_reads = 0;
  bit          resp_hold = 1'b0;
  logic [31:0] resp_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Handshake values are stable at negedge, so the model commits the upcoming transfer here.
  always @(negedge clk) begin
    dc_resp_valid = 1'b0;
    if (resp_cnt > 0 && !resp_hold) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        dc_resp_valid = 1'b1;
        dc_resp_rdata = resp_word;
      end
    end
    if (rst === 1'b1 && dc_req_valid === 1'b1 && dc_req_ready === 1'b1) begin
      if (dc_req_we) begin
        for (int b = 0; b < 4; b++)
          if (dc_req_wmask[b]) cmem[dc_req_addr[11:2]][8*b +: 8] = dc_req_wdata[8*b +: 8];
      end else begin
        resp_word = cmem[dc_req_addr[11:2]];
        resp_cnt  = 2;
        n_reads++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: rd=%0d data=%h want no output", out_rd, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_misalign", {31'd0, out_misalign}, {31'd0, mon_e.mis});
        if (mon_e.chk_rd) chk("out_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
        if (mon_e.chk_data) chk("out_data", out_data, mon_e.data);
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    int n = 0;
    in_valid = 1'b1; in_is_load = ld; in_is_store = st;
    in_funct3 = f3; in_addr = a; in_wdata = d; in_rd = rd;
    #1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (n == 200) fail("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [31:0] d, input logic mis,
                          input bit crd, input bit cdata);
    exp_t e;
    e.rd = rd; e.data = d; e.mis = mis; e.chk_rd = crd; e.chk_data = cdata;
    exp_q.push_back(e);
  endtask

  task automatic do_st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    push_exp(5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 1'b1, f3, a, d, 5'd17);
  endtask

  task automatic do_ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                       input logic [31:0] expd);
    push_exp(rd, expd, 1'b0, 1'b1, 1'b1);
    issue(1'b1, 1'b0, f3, a, 32'd0, rd);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || sb_empty !== 1'b1 || in_ready !== 1'b1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 300) fail("idle_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, exp_reads;
    for (int i = 0; i < 1024; i++) cmem[i] = '0;
    cmem[32'h300 >> 2] = 32'hAAAA_5678;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_misalign", {31'd0, out_misalign}, 32'd0);
    chk("rst_dc_req_valid", {31'd0, dc_req_valid}, 32'd0);
    chk("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Pass-through op returns the address.
    push_exp(5'd2, 32'h0000_0ABC, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0ABC, 32'd0, 5'd2);
    wait_idle();

    // SW then LW to the same word.
    r0 = n_reads;
    do_st(3'b010, 32'h100, 32'hDEAD_BEEF);
    chk("st_out_valid_next", {31'd0, out_valid}, 32'd1);
    do_ld(3'b010, 32'h100, 5'd7, 32'hDEAD_BEEF);
`ifdef MEM_LSU_FWD_EN
    chk("fwd_out_valid_next", {31'd0, out_valid}, 32'd1);
    exp_reads = r0;
`else
    chk("haz_in_ready", {31'd0, in_ready}, 32'd0);
    exp_reads = r0 + 1;
`endif
    wait_idle();
    chk("t1_reads", exp_reads, n_reads);

    // SB then LB on the same byte; later LBU reads it back from the cache.
    do_st(3'b000, 32'h203, 32'h0000_0080);
    do_ld(3'b000, 32'h203, 5'd9, 32'hFFFF_FF80);
    wait_idle();
    do_ld(3'b100, 32'h203, 5'd9, 32'h0000_0080);
    wait_idle();

    // SH into upper half, LW of the whole word must wait for the drain.
    dc_req_ready = 1'b0;
    do_st(3'b001, 32'h302, 32'h0000_1234);
    do_ld(3'b010, 32'h300, 5'd10, 32'h1234_5678);
    chk("t3_haz_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_drain_we", {31'd0, dc_req_we}, 32'd1);
    chk("t3_drain_addr", dc_req_addr, 32'h300);
    chk("t3_drain_wmask", {28'd0, dc_req_wmask}, 32'h0000_000C);
    chk("t3_drain_wdata", dc_req_wdata, 32'h1234_0000);
    dc_req_ready = 1'b1;
    wait_idle();
    do_ld(3'b001, 32'h302, 5'd11, 32'h0000_1234);
    do_ld(3'b100, 32'h301, 5'd12, 32'h0000_0056);
    do_ld(3'b001, 32'h300, 5'd13, 32'h0000_5678);
    wait_idle();
    do_st(3'b001, 32'h300, 32'h0000_8001);
    wait_idle();
    do_ld(3'b001, 32'h300, 5'd14, 32'hFFFF_8001);
    do_ld(3'b101, 32'h300, 5'd15, 32'h0000_8001);
    wait_idle();

    // Fill the SB with the port stalled, then let exactly one entry drain.
    dc_req_ready = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) do_st(3'b010, 32'h400 + 32'(4 * i), 32'(i + 1));
    chk("t4_head_valid", {31'd0, dc_req_valid}, 32'd1);
    chk("t4_head_addr", dc_req_addr, 32'h400);
    chk("t4_head_wmask", {28'd0, dc_req_wmask}, 32'h0000_000F);
    chk("t4_head_wdata", dc_req_wdata, 32'h1);
    in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = 3'b010; in_addr = 32'h410;
    in_wdata = 32'h5; in_rd = 5'd1;
    #1;
    chk("t4_full_not_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("t4_still_full", {31'd0, in_ready}, 32'd0);
    dc_req_ready = 1'b1;
    @(posedge clk); #1;
    dc_req_ready = 1'b0;
    push_exp(5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("t4_ready_after_pop", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_is_store = 1'b0;
    chk("t4_head_after_pop", dc_req_addr, 32'h404);
    dc_req_ready = 1'b1;
    wait_idle();
    do_ld(3'b010, 32'h400, 5'd3, 32'h1);
    do_ld(3'b010, 32'h40C, 5'd4, 32'h4);
    do_ld(3'b010, 32'h410, 5'd5, 32'h5);
    wait_idle();

    // Misaligned accesses: flagged next cycle, no port activity.
    push_exp(5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'b001, 32'h101, 32'd0, 5'd4);
    chk("mis_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mis_out_misalign", {31'd0, out_misalign}, 32'd1);
    push_exp(5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 3'b010, 32'h102, 32'h5555_5555, 5'd4);
    push_exp(5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 3'b010, 32'h106, 32'd0, 5'd4);
    repeat (3) begin
      @(negedge clk);
      chk("mis_no_req", {31'd0, dc_req_valid}, 32'd0);
      chk("mis_sb_empty", {31'd0, sb_empty}, 32'd1);
    end
    @(posedge clk); #1;
    wait_idle();

    // Reset while a read is outstanding and two stores are buffered.
    dc_req_ready = 1'b0;
    do_st(3'b010, 32'h500, 32'h1111_1111);
    do_st(3'b010, 32'h504, 32'h2222_2222);
    resp_hold = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'd0, 5'd12);
    dc_req_ready = 1'b1;
    @(posedge clk); #1;
    dc_req_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_wait_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_wait_sb_busy", {31'd0, sb_empty}, 32'd0);
    chk("t6_wait_no_req", {31'd0, dc_req_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_dc_req_valid", {31'd0, dc_req_valid}, 32'd0);
    chk("t6_rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_rst_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    dc_req_ready = 1'b1;
    resp_hold = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_idle_no_req", {31'd0, dc_req_valid}, 32'd0);
    chk("t6_stores_dropped", cmem[32'h500 >> 2], 32'd0);
    do_ld(3'b010, 32'h100, 5'd6, 32'hDEAD_BEEF);
    wait_idle();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
